mem_copy_master: RTL and testbench

Memory-port initiator that drives the single-port word memory model (`wen`/`a`/`d`/`q` interface) to perform block copy and block fill operations. It sits between the test harness or control logic and the memory model, taking a start/length command and issuing a sequence of read and write accesses. It reports completion with a one-cycle done pulse.

---
 rtl/mem_copy_master.sv | 183 ++++++++++++++++++
 tb/tb_mem_copy_master.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_master.sv
// mem_copy_master
//   Memory-port initiator for a single-port word memory (wen/a/d/q). Accepts a
//   start/length command and performs either a block copy (read src, write dst,
//   one word at a time, ascending) or a block fill (write pattern to dst).
//   Completion is reported with a one-cycle done pulse.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst_n       : asynchronous active-low reset
//   start       : command strobe, only sampled while idle
//   mode        : 0 = copy, 1 = fill
//   src, dst    : source / destination byte addresses
//   len         : number of words to transfer
//   pattern     : fill value
//   busy        : high while reading or writing
//   done        : one-cycle completion pulse
//   words_done  : words written since the last accepted command
//   mem_wen     : memory write enable (1 = write, 0 = read)
//   mem_a       : memory byte address
//   mem_d       : memory write data
//   mem_q       : memory read data (combinational from mem_a)
//
// Every output is decoded from registered state, so there is no combinational
// path from any input to any output.
module mem_copy_master #(
  parameter int BITS  = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [BITS-1:0]  src,
  input  logic [BITS-1:0]  dst,
  input  logic [LEN_W-1:0] len,
  input  logic [BITS-1:0]  pattern,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_wen,
  output logic [BITS-1:0]  mem_a,
  output logic [BITS-1:0]  mem_d,
  input  logic [BITS-1:0]  mem_q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [BITS-1:0]  r_src_ptr;
  logic [BITS-1:0]  r_dst_ptr;
  logic [BITS-1:0]  r_data;
  logic [BITS-1:0]  r_pattern;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_words_done;
  logic             r_mode;

  logic             w_accept;

  // Step a byte pointer by one word. Adding 4 leaves the two low address bits
  // untouched and wraps silently modulo 2^BITS.
  function automatic logic [BITS-1:0] f_next_word(input logic [BITS-1:0] a);
    return a + BITS'(4);
  endfunction

  assign w_accept = (r_state == S_IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            w_next = S_DONE;
          end else if (mode) begin
            w_next = S_WRITE;
          end else begin
            w_next = S_READ;
          end
        end
      end
      S_READ: begin
        w_next = S_WRITE;
      end
      S_WRITE: begin
        // Last word when the count is about to drop to zero.
        if (r_remaining == LEN_W'(1)) begin
          w_next = S_DONE;
        end else if (r_mode) begin
          w_next = S_WRITE;
        end else begin
          w_next = S_READ;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Command latch and transfer datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_ptr    <= '0;
      r_dst_ptr    <= '0;
      r_data       <= '0;
      r_pattern    <= '0;
      r_remaining  <= '0;
      r_words_done <= '0;
      r_mode       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_src_ptr    <= src;
        r_dst_ptr    <= dst;
        r_pattern    <= pattern;
        r_remaining  <= len;
        r_mode       <= mode;
        r_words_done <= '0;
      end
      if (r_state == S_READ) begin
        // Read data is captured verbatim, whatever the memory returns.
        r_data <= mem_q;
      end
      if (r_state == S_WRITE) begin
        r_dst_ptr    <= f_next_word(r_dst_ptr);
        r_remaining  <= r_remaining - LEN_W'(1);
        r_words_done <= r_words_done + LEN_W'(1);
        if (!r_mode) begin
          r_src_ptr <= f_next_word(r_src_ptr);
        end
      end
    end
  end

  // Output decode, from registered state only
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    mem_wen = 1'b0;
    mem_a   = '0;
    mem_d   = '0;
    case (r_state)
      S_READ: begin
        busy  = 1'b1;
        mem_a = r_src_ptr;
      end
      S_WRITE: begin
        busy    = 1'b1;
        mem_wen = 1'b1;
        mem_a   = r_dst_ptr;
        mem_d   = r_mode ? r_pattern : r_data;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign words_done = r_words_done;

endmodule

// File: tb/tb_mem_copy_master.sv
// Testbench for mem_copy_master: a sparse word memory, a trace-level reference
// model (expected per-cycle memory accesses derived from the command), a
// per-cycle compare process, and directed plus randomized commands.
module tb_mem_copy_master;

  localparam int BITS  = 32;
  localparam int LEN_W = 16;
  localparam int NWORD = 320;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic [BITS-1:0]  src;
  logic [BITS-1:0]  dst;
  logic [LEN_W-1:0] len;
  logic [BITS-1:0]  pattern;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] words_done;
  logic             mem_wen;
  logic [BITS-1:0]  mem_a;
  logic [BITS-1:0]  mem_d;
  logic [BITS-1:0]  mem_q;

  always #5 clk = ~clk;

  mem_copy_master #(.BITS(BITS), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .pattern(pattern), .busy(busy), .done(done),
    .words_done(words_done), .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d),
    .mem_q(mem_q)
  );

  // Mapped 256-byte windows: 0x00000000, 0x00001000, 0x00002000, 0x00003000,
  // 0xFFFFFF00. Each holds 64 words.
  function automatic int midx(input logic [31:0] a);
    int r;
    r = -1;
    case (a[31:8])
      24'h000000: r = 0;
      24'h000010: r = 1;
      24'h000020: r = 2;
      24'h000030: r = 3;
      24'hFFFFFF: r = 4;
      default:    r = -1;
    endcase
    if (r < 0) return -1;
    return r * 64 + int'(a[7:2]);
  endfunction

  logic [31:0] memw      [0:NWORD-1] = '{default: '0};
  logic [31:0] model_mem [0:NWORD-1] = '{default: '0};

  always_comb begin
    mem_q = '0;
    if (midx(mem_a) >= 0) mem_q = memw[midx(mem_a)];
  end

  always @(posedge clk) begin
    if (mem_wen && midx(mem_a) >= 0) memw[midx(mem_a)] <= mem_d;
  end

  function automatic logic [31:0] rdm(input logic [31:0] a);
    if (midx(a) < 0) return 32'h0;
    return memw[midx(a)];
  endfunction

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] a;
    logic [31:0] d;
    logic        busy;
    logic        done;
    logic [15:0] wd;
  } exp_t;

  exp_t        q[$];
  logic [15:0] model_wd = '0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  int          wen_cnt = 0;
  int          last_done_cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Expected cycle-by-cycle trace for one accepted command. Copy reads go
  // through a private image of memory so overlapping regions see the words
  // already written by earlier iterations.
  task automatic push_trace(input logic m, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, input logic [31:0] pat);
    logic [31:0] sim [0:NWORD-1];
    logic [31:0] sa, da, val;
    exp_t e;
    sim = model_mem;
    for (int i = 0; i < int'(n); i++) begin
      sa = s + 32'(i) * 32'd4;
      da = d + 32'(i) * 32'd4;
      if (m) begin
        val = pat;
      end else begin
        val = (midx(sa) >= 0) ? sim[midx(sa)] : 32'h0;
        e = '{wen: 1'b0, a: sa, d: 32'h0, busy: 1'b1, done: 1'b0, wd: 16'(i)};
        q.push_back(e);
      end
      e = '{wen: 1'b1, a: da, d: val, busy: 1'b1, done: 1'b0, wd: 16'(i)};
      q.push_back(e);
      if (midx(da) >= 0) sim[midx(da)] = val;
    end
    e = '{wen: 1'b0, a: 32'h0, d: 32'h0, busy: 1'b0, done: 1'b1, wd: n};
    q.push_back(e);
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial forever begin
    exp_t e;
    logic chk_d;
    @(negedge clk);
    if (!rst_n) begin
      e = '{wen: 1'b0, a: 32'h0, d: 32'h0, busy: 1'b0, done: 1'b0, wd: 16'h0};
    end else if (q.size() > 0) begin
      e = q.pop_front();
    end else begin
      e = '{wen: 1'b0, a: 32'h0, d: 32'h0, busy: 1'b0, done: 1'b0, wd: model_wd};
    end
    chk_d = !(e.busy && !e.wen);
    n_assert++;
    if (busy !== e.busy || done !== e.done || mem_wen !== e.wen || mem_a !== e.a ||
        (chk_d && mem_d !== e.d) || words_done !== e.wd) begin
      n_fail++;
      $display("FAIL cycle_cmp cyc=%0d got busy=%b done=%b wen=%b a=%h d=%h wd=%0d required busy=%b done=%b wen=%b a=%h d=%h wd=%0d",
               cyc, busy, done, mem_wen, mem_a, mem_d, words_done,
               e.busy, e.done, e.wen, e.a, e.d, e.wd);
    end
    if (rst_n) begin
      if (e.wen && midx(e.a) >= 0) model_mem[midx(e.a)] = e.d;
      model_wd = e.wd;
    end
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (busy) busy_cnt++;
    if (mem_wen) wen_cnt++;
  end

  // Issue one command. Must be called just after a rising edge while idle;
  // returns just after the accepting edge with c0 set so that cycle k of the
  // command is observed when cyc == c0 + k - 1.
  task automatic cmd(input logic m, input logic [31:0] s, input logic [31:0] d,
                     input logic [15:0] n, input logic [31:0] pat, output int c0);
    start   = 1'b1;
    mode    = m;
    src     = s;
    dst     = d;
    len     = n;
    pattern = pat;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0 = cyc;
    push_trace(m, s, d, n, pat);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 200000 / 1000) begin
        n_assert++;
        n_fail++;
        $display("FAIL wait_idle: got %0d pending cycles required 0", q.size());
        q.delete();
      end
    end
  endtask

  initial begin
    int c0;
    logic        rm;
    logic [31:0] rs, rd, rp;
    logic [15:0] rl;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    src = '0; dst = '0; len = '0; pattern = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_wen_a_d", mem_a | mem_d | {31'h0, mem_wen} | {16'h0, words_done}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill 4 words at 0x1000
    busy_cnt = 0;
    cmd(1'b1, 32'h0, 32'h1000, 16'd4, 32'hA5A5A5A5, c0);
    wait_idle();
    check("fill_done_cycle", 32'(last_done_cyc - c0 + 1), 32'd5);
    check("fill_busy_cycles", 32'(busy_cnt), 32'd4);
    check("fill_words_done", {16'h0, words_done}, 32'd4);
    for (int i = 0; i < 4; i++) check("fill_mem", rdm(32'h1000 + 32'(i) * 4), 32'hA5A5A5A5);

    // Preload 1..4 with single-word fills, then copy to 0x1040
    for (int i = 0; i < 4; i++) begin
      cmd(1'b1, 32'h0, 32'h1000 + 32'(i) * 4, 16'd1, 32'(i + 1), c0);
      wait_idle();
    end
    cmd(1'b0, 32'h1000, 32'h1040, 16'd4, 32'h0, c0);
    wait_idle();
    check("copy_done_cycle", 32'(last_done_cyc - c0 + 1), 32'd9);
    for (int i = 0; i < 4; i++) begin
      check("copy_dst", rdm(32'h1040 + 32'(i) * 4), 32'(i + 1));
      check("copy_src_kept", rdm(32'h1000 + 32'(i) * 4), 32'(i + 1));
    end

    // Zero length in both modes
    for (int m = 0; m < 2; m++) begin
      busy_cnt = 0;
      wen_cnt  = 0;
      cmd(m[0], 32'h1000, 32'h1080, 16'd0, 32'hFFFFFFFF, c0);
      wait_idle();
      check("zero_done_cycle", 32'(last_done_cyc - c0 + 1), 32'd1);
      check("zero_busy", 32'(busy_cnt), 32'd0);
      check("zero_wen", 32'(wen_cnt), 32'd0);
    end

    // Start pulsed during cycle 3 of an 8-word copy
    done_cnt = 0;
    cmd(1'b0, 32'h1000, 32'h1080, 16'd8, 32'h0, c0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1; dst = 32'h10C0; pattern = 32'hDEADBEEF; len = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    check("busy_start_one_done", 32'(done_cnt), 32'd1);
    check("busy_start_done_cycle", 32'(last_done_cyc - c0 + 1), 32'd17);
    check("busy_start_no_write", rdm(32'h10C0), 32'h0);
    for (int i = 0; i < 4; i++) check("busy_start_dst", rdm(32'h1080 + 32'(i) * 4), 32'(i + 1));

    // Address wrap-around
    cmd(1'b1, 32'h0, 32'hFFFFFFFC, 16'd2, 32'h5A5A1234, c0);
    wait_idle();
    check("wrap_done_cycle", 32'(last_done_cyc - c0 + 1), 32'd3);
    check("wrap_hi", rdm(32'hFFFFFFFC), 32'h5A5A1234);
    check("wrap_lo", rdm(32'h00000000), 32'h5A5A1234);

    // Reset during the write of word 2 of a 4-word fill
    done_cnt = 0;
    cmd(1'b1, 32'h0, 32'h3000, 16'd4, 32'hC0DEC0DE, c0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    model_wd = '0;
    #1;
    check("rst_mid_wen", {31'h0, mem_wen}, 32'h0);
    check("rst_mid_words_done", {16'h0, words_done}, 32'h0);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_no_done", 32'(done_cnt), 32'd0);
    check("rst_mid_word1", rdm(32'h3000), 32'hC0DEC0DE);
    check("rst_mid_word3", rdm(32'h3008), 32'h0);
    check("rst_mid_word4", rdm(32'h300C), 32'h0);
    cmd(1'b1, 32'h0, 32'h3000, 16'd4, 32'h11112222, c0);
    wait_idle();
    check("rst_after_done_cycle", 32'(last_done_cyc - c0 + 1), 32'd5);
    check("rst_after_word4", rdm(32'h300C), 32'h11112222);

    // Randomized commands in the 0x2000 window, back-to-back, with stray starts
    for (int it = 0; it < 40; it++) begin
      rm = 1'($urandom_range(0, 1));
      rs = 32'h2000 + 32'($urandom_range(0, 55)) * 4 + 32'($urandom_range(0, 3));
      rd = 32'h2000 + 32'($urandom_range(0, 55)) * 4 + 32'($urandom_range(0, 3));
      rl = 16'($urandom_range(0, 8));
      rp = $urandom;
      cmd(rm, rs, rd, rl, rp, c0);
      if (rl != 0 && $urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        start = 1'b1; mode = ~rm; dst = 32'h2000; src = 32'h2004; len = 16'd7; pattern = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
      end
      wait_idle();
    end
    for (int i = 0; i < 64; i++) begin
      check("rand_mem_image", rdm(32'h2000 + 32'(i) * 4), model_mem[2 * 64 + i]);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
